// File: rtl/reservation_station_pkg.sv
// rtl/reservation_station_pkg.sv - shared widths, defaults and entry record for the reservation station
package reservation_station_pkg;

    localparam int RS_SIZE_DEF = 16;
    localparam int ROB_W_DEF   = 6;
    localparam int OPCODE_W    = 6;
    localparam int DATA_W      = 32;

    typedef struct packed {
        logic                busy;
        logic [OPCODE_W-1:0] opcode;
        logic [DATA_W-1:0]   val1;
        logic [DATA_W-1:0]   val2;
        logic [ROB_W_DEF-1:0] dep1;
        logic [ROB_W_DEF-1:0] dep2;
        logic                has_dep1;
        logic                has_dep2;
        logic [ROB_W_DEF-1:0] rob_index;
        logic [DATA_W-1:0]   imm;
        logic [DATA_W-1:0]   pc;
    } rs_entry_t;

endpackage

// File: rtl/reservation_station_priority_encoder.sv
// rtl/reservation_station_priority_encoder.sv - lowest-set-bit finder (module rs_priority_encoder)
module rs_priority_encoder #(
    parameter int N     = 16,
    parameter int IDX_W = $clog2(N)
) (
    input  logic [N-1:0]     req_i,
    output logic             found_o,
    output logic [IDX_W-1:0] idx_o
);

    // Scanning downward lets the lowest set bit win the last assignment.
    always_comb begin
        found_o = 1'b0;
        idx_o   = '0;
        for (int i = N - 1; i >= 0; i--) begin
            if (req_i[i]) begin
                found_o = 1'b1;
                idx_o   = IDX_W'(i);
            end
        end
    end

endmodule

// File: rtl/reservation_station.sv
// rtl/reservation_station.sv - CDB-snooping reservation station; optional RS_ISSUE_BYPASS_EN same-cycle wakeup of issues
module reservation_station
    import reservation_station_pkg::*;
#(
    parameter int RS_SIZE = RS_SIZE_DEF,
    parameter int ROB_W   = ROB_W_DEF
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                rdy,
    input  logic                rs_valid,
    input  logic [OPCODE_W-1:0] rs_opcode,
    input  logic [DATA_W-1:0]   rs_val1,
    input  logic [DATA_W-1:0]   rs_val2,
    input  logic [ROB_W-1:0]    rs_dep1,
    input  logic [ROB_W-1:0]    rs_dep2,
    input  logic                rs_has_dep1,
    input  logic                rs_has_dep2,
    input  logic [ROB_W-1:0]    rs_rob_index,
    input  logic [DATA_W-1:0]   rs_imm,
    input  logic [DATA_W-1:0]   rs_pc,
    input  logic                cdb_valid,
    input  logic [ROB_W-1:0]    cdb_rob_index,
    input  logic [DATA_W-1:0]   cdb_value,
    input  logic                flush,
    output logic                rs_full,
    output logic                alu_valid,
    output logic [OPCODE_W-1:0] alu_opcode,
    output logic [DATA_W-1:0]   alu_val1,
    output logic [DATA_W-1:0]   alu_val2,
    output logic [DATA_W-1:0]   alu_imm,
    output logic [DATA_W-1:0]   alu_pc,
    output logic [ROB_W-1:0]    alu_rob_index
);

    localparam int IDX_W = $clog2(RS_SIZE);

    rs_entry_t entries_q [RS_SIZE];
    rs_entry_t entries_d [RS_SIZE];
    rs_entry_t new_entry;

    logic                alu_valid_q, alu_valid_d;
    logic [OPCODE_W-1:0] alu_opcode_q, alu_opcode_d;
    logic [DATA_W-1:0]   alu_val1_q, alu_val1_d, alu_val2_q, alu_val2_d;
    logic [DATA_W-1:0]   alu_imm_q, alu_imm_d, alu_pc_q, alu_pc_d;
    logic [ROB_W-1:0]    alu_rob_q, alu_rob_d;

    logic [RS_SIZE-1:0] busy_vec, ready_vec;
    logic [IDX_W:0]     busy_cnt;
    logic               alloc_found, sel_found;
    logic [IDX_W-1:0]   alloc_idx, sel_idx;

    always_comb begin
        busy_vec  = '0;
        ready_vec = '0;
        busy_cnt  = '0;
        for (int i = 0; i < RS_SIZE; i++) begin
            busy_vec[i]  = entries_q[i].busy;
            ready_vec[i] = entries_q[i].busy && !entries_q[i].has_dep1 && !entries_q[i].has_dep2;
            busy_cnt     = busy_cnt + (IDX_W+1)'(entries_q[i].busy);
        end
    end

    // One spare slot absorbs the issuer's registered reaction delay.
    assign rs_full = busy_cnt > (IDX_W+1)'(RS_SIZE - 2);

    rs_priority_encoder #(.N(RS_SIZE)) u_alloc_enc (
        .req_i   (~busy_vec),
        .found_o (alloc_found),
        .idx_o   (alloc_idx)
    );

    rs_priority_encoder #(.N(RS_SIZE)) u_select_enc (
        .req_i   (ready_vec),
        .found_o (sel_found),
        .idx_o   (sel_idx)
    );

    always_comb begin
        new_entry           = '0;
        new_entry.busy      = 1'b1;
        new_entry.opcode    = rs_opcode;
        new_entry.val1      = rs_val1;
        new_entry.val2      = rs_val2;
        new_entry.dep1      = rs_dep1;
        new_entry.dep2      = rs_dep2;
        new_entry.has_dep1  = rs_has_dep1;
        new_entry.has_dep2  = rs_has_dep2;
        new_entry.rob_index = rs_rob_index;
        new_entry.imm       = rs_imm;
        new_entry.pc        = rs_pc;
`ifdef RS_ISSUE_BYPASS_EN
        if (cdb_valid && rs_has_dep1 && rs_dep1 == cdb_rob_index) begin
            new_entry.val1     = cdb_value;
            new_entry.has_dep1 = 1'b0;
        end
        if (cdb_valid && rs_has_dep2 && rs_dep2 == cdb_rob_index) begin
            new_entry.val2     = cdb_value;
            new_entry.has_dep2 = 1'b0;
        end
`endif
    end

    // Dispatch, wakeup and allocate touch disjoint entries, so their order here is free.
    always_comb begin
        entries_d    = entries_q;
        alu_valid_d  = 1'b0;
        alu_opcode_d = alu_opcode_q;
        alu_val1_d   = alu_val1_q;
        alu_val2_d   = alu_val2_q;
        alu_imm_d    = alu_imm_q;
        alu_pc_d     = alu_pc_q;
        alu_rob_d    = alu_rob_q;
        if (flush) begin
            for (int i = 0; i < RS_SIZE; i++) entries_d[i].busy = 1'b0;
        end else begin
            if (sel_found) begin
                alu_valid_d  = 1'b1;
                alu_opcode_d = entries_q[sel_idx].opcode;
                alu_val1_d   = entries_q[sel_idx].val1;
                alu_val2_d   = entries_q[sel_idx].val2;
                alu_imm_d    = entries_q[sel_idx].imm;
                alu_pc_d     = entries_q[sel_idx].pc;
                alu_rob_d    = entries_q[sel_idx].rob_index;
                entries_d[sel_idx].busy = 1'b0;
            end
            if (cdb_valid) begin
                for (int i = 0; i < RS_SIZE; i++) begin
                    if (entries_q[i].busy && entries_q[i].has_dep1 && entries_q[i].dep1 == cdb_rob_index) begin
                        entries_d[i].val1     = cdb_value;
                        entries_d[i].has_dep1 = 1'b0;
                    end
                    if (entries_q[i].busy && entries_q[i].has_dep2 && entries_q[i].dep2 == cdb_rob_index) begin
                        entries_d[i].val2     = cdb_value;
                        entries_d[i].has_dep2 = 1'b0;
                    end
                end
            end
            if (rs_valid && alloc_found) entries_d[alloc_idx] = new_entry;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < RS_SIZE; i++) entries_q[i] <= '0;
            alu_valid_q  <= 1'b0;
            alu_opcode_q <= '0;
            alu_val1_q   <= '0;
            alu_val2_q   <= '0;
            alu_imm_q    <= '0;
            alu_pc_q     <= '0;
            alu_rob_q    <= '0;
        end else if (rdy) begin
            entries_q    <= entries_d;
            alu_valid_q  <= alu_valid_d;
            alu_opcode_q <= alu_opcode_d;
            alu_val1_q   <= alu_val1_d;
            alu_val2_q   <= alu_val2_d;
            alu_imm_q    <= alu_imm_d;
            alu_pc_q     <= alu_pc_d;
            alu_rob_q    <= alu_rob_d;
        end
    end

    issue_when_full_a: assert property (@(posedge clk) disable iff (rst)
        (rdy && rs_valid && !flush) |-> alloc_found);

    assign alu_valid     = alu_valid_q;
    assign alu_opcode    = alu_opcode_q;
    assign alu_val1      = alu_val1_q;
    assign alu_val2      = alu_val2_q;
    assign alu_imm       = alu_imm_q;
    assign alu_pc        = alu_pc_q;
    assign alu_rob_index = alu_rob_q;

endmodule

// File: tb/tb_reservation_station.sv
// tb/tb_reservation_station.sv - directed and randomized bench for reservation_station against an in-bench model
module tb_reservation_station;

    localparam int N = 16;

    logic        clk, rst, rdy, rs_valid, rs_has_dep1, rs_has_dep2, cdb_valid, flush;
    logic [5:0]  rs_opcode, rs_dep1, rs_dep2, rs_rob_index, cdb_rob_index;
    logic [31:0] rs_val1, rs_val2, rs_imm, rs_pc, cdb_value;
    logic        rs_full, alu_valid;
    logic [5:0]  alu_opcode, alu_rob_index;
    logic [31:0] alu_val1, alu_val2, alu_imm, alu_pc;

    reservation_station dut (
        .clk(clk), .rst(rst), .rdy(rdy),
        .rs_valid(rs_valid), .rs_opcode(rs_opcode), .rs_val1(rs_val1), .rs_val2(rs_val2),
        .rs_dep1(rs_dep1), .rs_dep2(rs_dep2), .rs_has_dep1(rs_has_dep1), .rs_has_dep2(rs_has_dep2),
        .rs_rob_index(rs_rob_index), .rs_imm(rs_imm), .rs_pc(rs_pc),
        .cdb_valid(cdb_valid), .cdb_rob_index(cdb_rob_index), .cdb_value(cdb_value), .flush(flush),
        .rs_full(rs_full), .alu_valid(alu_valid), .alu_opcode(alu_opcode),
        .alu_val1(alu_val1), .alu_val2(alu_val2), .alu_imm(alu_imm), .alu_pc(alu_pc),
        .alu_rob_index(alu_rob_index)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;
    bit check_en = 1'b0;

    // Model: a slot table plus the value last handed to the ALU.
    bit          m_busy [N];
    bit          m_h1 [N], m_h2 [N];
    logic [5:0]  m_op [N], m_d1 [N], m_d2 [N], m_rob [N];
    logic [31:0] m_v1 [N], m_v2 [N], m_imm [N], m_pc [N];
    logic        exp_valid;
    logic [5:0]  exp_op, exp_rob;
    logic [31:0] exp_v1, exp_v2, exp_imm, exp_pc;
    int          m_a, m_s;

    function automatic int m_free();
        int f = 0;
        for (int i = 0; i < N; i++) if (!m_busy[i]) f++;
        return f;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    always @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < N; i++) m_busy[i] = 1'b0;
            exp_valid = 0; exp_op = 0; exp_rob = 0;
            exp_v1 = 0; exp_v2 = 0; exp_imm = 0; exp_pc = 0;
        end else if (rdy) begin
            if (flush) begin
                for (int i = 0; i < N; i++) m_busy[i] = 1'b0;
                exp_valid = 0;
            end else begin
                m_a = -1;
                m_s = -1;
                for (int i = 0; i < N; i++) begin
                    if (!m_busy[i] && m_a < 0) m_a = i;
                    if (m_busy[i] && !m_h1[i] && !m_h2[i] && m_s < 0) m_s = i;
                end
                exp_valid = (m_s >= 0);
                if (m_s >= 0) begin
                    exp_op = m_op[m_s]; exp_rob = m_rob[m_s];
                    exp_v1 = m_v1[m_s]; exp_v2 = m_v2[m_s];
                    exp_imm = m_imm[m_s]; exp_pc = m_pc[m_s];
                    m_busy[m_s] = 1'b0;
                end
                if (cdb_valid) begin
                    for (int i = 0; i < N; i++) begin
                        if (m_busy[i] && m_h1[i] && m_d1[i] == cdb_rob_index) begin m_v1[i] = cdb_value; m_h1[i] = 0; end
                        if (m_busy[i] && m_h2[i] && m_d2[i] == cdb_rob_index) begin m_v2[i] = cdb_value; m_h2[i] = 0; end
                    end
                end
                if (rs_valid && m_a >= 0) begin
                    m_busy[m_a] = 1; m_op[m_a] = rs_opcode; m_rob[m_a] = rs_rob_index;
                    m_v1[m_a] = rs_val1; m_v2[m_a] = rs_val2; m_imm[m_a] = rs_imm; m_pc[m_a] = rs_pc;
                    m_h1[m_a] = rs_has_dep1; m_h2[m_a] = rs_has_dep2;
                    m_d1[m_a] = rs_dep1; m_d2[m_a] = rs_dep2;
`ifdef RS_ISSUE_BYPASS_EN
                    if (cdb_valid && rs_has_dep1 && rs_dep1 == cdb_rob_index) begin m_v1[m_a] = cdb_value; m_h1[m_a] = 0; end
                    if (cdb_valid && rs_has_dep2 && rs_dep2 == cdb_rob_index) begin m_v2[m_a] = cdb_value; m_h2[m_a] = 0; end
`endif
                end
            end
        end
    end

    always @(negedge clk) begin
        if (check_en) begin
            chk("alu_valid", 32'(alu_valid), 32'(exp_valid));
            chk("alu_opcode", 32'(alu_opcode), 32'(exp_op));
            chk("alu_rob_index", 32'(alu_rob_index), 32'(exp_rob));
            chk("alu_val1", alu_val1, exp_v1);
            chk("alu_val2", alu_val2, exp_v2);
            chk("alu_imm", alu_imm, exp_imm);
            chk("alu_pc", alu_pc, exp_pc);
            chk("rs_full", 32'(rs_full), 32'(m_free() < 2));
        end
    end

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic idle();
        rs_valid = 0; cdb_valid = 0; flush = 0;
        rs_has_dep1 = 0; rs_has_dep2 = 0;
    endtask

    task automatic issue(input logic [5:0] op, input logic [31:0] v1, input logic [31:0] v2,
                         input logic h1, input logic [5:0] d1, input logic h2, input logic [5:0] d2,
                         input logic [5:0] rob);
        rs_valid = 1; rs_opcode = op; rs_val1 = v1; rs_val2 = v2;
        rs_has_dep1 = h1; rs_dep1 = d1; rs_has_dep2 = h2; rs_dep2 = d2;
        rs_rob_index = rob; rs_imm = $urandom; rs_pc = $urandom;
    endtask

    task automatic bcast(input logic [5:0] tag, input logic [31:0] val);
        cdb_valid = 1; cdb_rob_index = tag; cdb_value = val;
    endtask

    initial begin
        rst = 1; rdy = 1; idle();
        rs_opcode = 0; rs_val1 = 0; rs_val2 = 0; rs_dep1 = 0; rs_dep2 = 0;
        rs_rob_index = 0; rs_imm = 0; rs_pc = 0; cdb_rob_index = 0; cdb_value = 0;
        tick();
        check_en = 1;
        tick();
        chk("reset_alu_valid", 32'(alu_valid), 32'd0);
        chk("reset_alu_val1", alu_val1, 32'd0);
        chk("reset_rs_full", 32'(rs_full), 32'd0);
        rst = 0;

        issue(6'd3, 32'd5, 32'd7, 0, 6'd0, 0, 6'd0, 6'd2);
        tick(); idle();
        chk("ready_no_early", 32'(alu_valid), 32'd0);
        tick();
        chk("ready_valid", 32'(alu_valid), 32'd1);
        chk("ready_val1", alu_val1, 32'd5);
        chk("ready_val2", alu_val2, 32'd7);
        chk("ready_rob", 32'(alu_rob_index), 32'd2);
        chk("ready_op", 32'(alu_opcode), 32'd3);
        tick();
        chk("ready_pulse_end", 32'(alu_valid), 32'd0);

        issue(6'd4, 32'd1, 32'd2, 1, 6'd9, 0, 6'd0, 6'd3);
        tick(); idle(); tick();
        chk("wake_blocked", 32'(alu_valid), 32'd0);
        bcast(6'd9, 32'hDEADBEEF);
        tick(); idle(); tick();
        chk("wake_valid", 32'(alu_valid), 32'd1);
        chk("wake_val1", alu_val1, 32'hDEADBEEF);

        issue(6'd1, 32'd0, 32'd0, 1, 6'd4, 0, 6'd0, 6'd20);
        tick();
        issue(6'd1, 32'd0, 32'd0, 0, 6'd0, 1, 6'd4, 6'd21);
        tick(); idle();
        bcast(6'd4, 32'h1234);
        tick(); idle(); tick();
        chk("order_first", 32'(alu_rob_index), 32'd20);
        tick();
        chk("order_second", 32'(alu_rob_index), 32'd21);
        chk("order_second_v2", alu_val2, 32'h1234);
        tick();

        for (int k = 1; k <= 15; k++) begin
            issue(6'd2, 32'd0, 32'd0, 1, 6'd30, 0, 6'd0, 6'(k));
            tick();
            if (k == 14) chk("full_at_14", 32'(rs_full), 32'd0);
        end
        idle();
        chk("full_at_15", 32'(rs_full), 32'd1);
        bcast(6'd30, 32'h77);
        tick(); idle(); tick();
        chk("full_release", 32'(rs_full), 32'd0);
        chk("full_first_rob", 32'(alu_rob_index), 32'd1);
        repeat (16) tick();

        for (int k = 0; k < 5; k++) begin
            issue(6'd5, 32'd0, 32'd0, 1, 6'd40, 0, 6'd0, 6'(k + 1));
            tick();
        end
        issue(6'd6, 32'd9, 32'd9, 0, 6'd0, 0, 6'd0, 6'd45);
        flush = 1;
        tick(); idle();
        chk("flush_valid", 32'(alu_valid), 32'd0);
        issue(6'd7, 32'd11, 32'd12, 0, 6'd0, 0, 6'd0, 6'd50);
        tick(); idle(); tick();
        chk("flush_after_valid", 32'(alu_valid), 32'd1);
        chk("flush_after_rob", 32'(alu_rob_index), 32'd50);
        bcast(6'd40, 32'h1);
        tick(); idle(); tick();
        chk("flush_no_stale", 32'(alu_valid), 32'd0);

        issue(6'd8, 32'd3, 32'd0, 0, 6'd0, 1, 6'd12, 6'd13);
        bcast(6'd12, 32'h55);
        tick(); idle(); tick();
`ifdef RS_ISSUE_BYPASS_EN
        chk("bypass_valid", 32'(alu_valid), 32'd1);
        chk("bypass_val2", alu_val2, 32'h55);
`else
        chk("bypass_blocked", 32'(alu_valid), 32'd0);
`endif
        flush = 1;
        tick(); idle();

        for (int c = 0; c < 3000; c++) begin
            rst = ($urandom_range(0, 499) == 0);
            rdy = ($urandom_range(0, 9) != 0);
            flush = ($urandom_range(0, 49) == 0);
            rs_valid = 0;
            if ($urandom_range(0, 1) == 1 && m_free() > 0)
                issue(6'($urandom), $urandom, $urandom,
                      $urandom_range(0, 2) == 0, 6'($urandom_range(1, 7)),
                      $urandom_range(0, 2) == 0, 6'($urandom_range(1, 7)), 6'($urandom_range(1, 63)));
            cdb_valid = ($urandom_range(0, 2) == 0);
            cdb_rob_index = 6'($urandom_range(1, 7));
            cdb_value = $urandom;
            tick();
        end
        rst = 0; rdy = 1; idle();
        tick();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
